npu_log_snooper: RTL and testbench

//  Drains the core/memory transaction logger: issues snoop requests, reads the event count, walks the log SRAM.

---
 rtl/npu_log_snooper_pkg.sv | 44 ++++
 rtl/npu_log_snooper.sv | 178 +++++++++++++++++
 tb/tb_npu_log_snooper.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_log_snooper_pkg.sv
// Shared types for the NPU transaction-logger snoop and dump path.
// Holds the logger request codes, the dump FSM states and the logged-entry layout.
package npu_log_snooper_pkg;

  localparam int LOG_ADDR_W = 32;
  localparam int LOG_DATA_W = 512;

  typedef enum logic [1:0] {
    SNOOP_CORE      = 2'd0,
    SNOOP_MEM       = 2'd1,
    GET_CORE_EVENTS = 2'd2,
    GET_MEM_EVENTS  = 2'd3
  } log_snoop_req_enum_t;

  typedef log_snoop_req_enum_t log_snoop_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_CNT,
    ST_WAIT_CNT,
    ST_REQ_ENT,
    ST_WAIT_ENT,
    ST_EMIT,
    ST_DONE
  } log_dump_state_t;

  typedef struct packed {
    logic [LOG_ADDR_W-1:0] addr;
    logic [LOG_DATA_W-1:0] data;
    logic [LOG_ADDR_W-1:0] id;
    logic                  is_write;
    logic                  is_read;
  } log_dump_entry_t;

  // src: 0 = core log, 1 = memory log
  function automatic log_snoop_req_t entry_req(input logic src);
    return src ? SNOOP_MEM : SNOOP_CORE;
  endfunction

  function automatic log_snoop_req_t count_req(input logic src);
    return src ? GET_MEM_EVENTS : GET_CORE_EVENTS;
  endfunction

endpackage

// File: rtl/npu_log_snooper.sv
// Drains the transaction logger: reads the event count, walks the log SRAM oldest-first
// and streams each entry to the host valid/ready port. Optional macro: NPU_LOG_SNOOPER_FILTER_EN.
//
// state       | meaning
// ST_IDLE     | waiting for dump_start_i
// ST_REQ_CNT  | issue GET_*_EVENTS to the logger
// ST_WAIT_CNT | wait for the event count, compute walk length and first index
// ST_REQ_ENT  | issue SNOOP_* for the current index
// ST_WAIT_ENT | wait for the logged entry, capture it
// ST_EMIT     | present the entry until the host accepts it
// ST_DONE     | one-cycle completion pulse
module npu_log_snooper
  import npu_log_snooper_pkg::*;
#(
  parameter int LOG_SIZE   = 512,
  parameter int DATA_WIDTH = LOG_DATA_W,
  parameter int ADDR_WIDTH = LOG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dump_start_i,
  input  logic                  dump_source_i,
  input  logic                  dump_abort_i,
`ifdef NPU_LOG_SNOOPER_FILTER_EN
  input  logic [ADDR_WIDTH-1:0] filter_lo_i,
  input  logic [ADDR_WIDTH-1:0] filter_hi_i,
`endif
  output logic                  snoop_valid_o,
  output log_snoop_req_t        snoop_request_o,
  output logic [ADDR_WIDTH-1:0] snoop_addr_o,
  input  logic                  cl_valid_i,
  input  logic [ADDR_WIDTH-1:0] cl_req_addr_i,
  input  logic [DATA_WIDTH-1:0] cl_req_data_i,
  input  logic [ADDR_WIDTH-1:0] cl_req_id_i,
  input  logic                  cl_req_is_write_i,
  input  logic                  cl_req_is_read_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic [ADDR_WIDTH-1:0] dump_id_o,
  output logic                  dump_is_write_o,
  output logic                  dump_is_read_o,
  output logic                  dump_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDX_W = $clog2(LOG_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LOG_SIZE_A = ADDR_WIDTH'(LOG_SIZE);
  localparam logic [CNT_W-1:0]      LOG_SIZE_N = CNT_W'(LOG_SIZE);

  log_dump_state_t  state_q, state_d;
  logic             src_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] left_q;
  log_dump_entry_t  entry_q;

  logic             start_ok;
  logic             in_window;
  logic             last_entry;
  logic             cnt_load;
  logic             ent_capture;
  logic             ent_advance;
  logic [CNT_W-1:0] walk_n;
  logic [IDX_W-1:0] walk_first;

  assign start_ok   = dump_start_i && !dump_abort_i;
  assign last_entry = (left_q == CNT_W'(1));

  // Once the logger has wrapped, the oldest surviving entry sits at C mod LOG_SIZE.
  always_comb begin
    walk_n     = cl_req_id_i[CNT_W-1:0];
    walk_first = '0;
    if (cl_req_id_i > LOG_SIZE_A) begin
      walk_n     = LOG_SIZE_N;
      walk_first = cl_req_id_i[IDX_W-1:0];
    end
  end

`ifdef NPU_LOG_SNOOPER_FILTER_EN
  assign in_window = (cl_req_addr_i >= filter_lo_i) && (cl_req_addr_i <= filter_hi_i);
`else
  assign in_window = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    ent_capture = 1'b0;
    ent_advance = 1'b0;
    case (state_q)
      ST_IDLE:     if (start_ok) state_d = ST_REQ_CNT;
      ST_REQ_CNT:  state_d = ST_WAIT_CNT;
      ST_WAIT_CNT: begin
        if (cl_valid_i) begin
          cnt_load = 1'b1;
          state_d  = (walk_n == '0) ? ST_DONE : ST_REQ_ENT;
        end
      end
      ST_REQ_ENT:  state_d = ST_WAIT_ENT;
      ST_WAIT_ENT: begin
        if (cl_valid_i) begin
          if (in_window) begin
            ent_capture = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            ent_advance = 1'b1;
            state_d     = last_entry ? ST_DONE : ST_REQ_ENT;
          end
        end
      end
      ST_EMIT: begin
        if (dump_ready_i) begin
          ent_advance = 1'b1;
          state_d     = last_entry ? ST_DONE : ST_REQ_ENT;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a response landing in the same cycle.
    if (dump_abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      cnt_load    = 1'b0;
      ent_capture = 1'b0;
      ent_advance = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= 1'b0;
      idx_q   <= '0;
      left_q  <= '0;
      entry_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start_ok) src_q <= dump_source_i;
      if (cnt_load) begin
        idx_q  <= walk_first;
        left_q <= walk_n;
      end
      if (ent_capture) begin
        entry_q.addr     <= cl_req_addr_i;
        entry_q.data     <= cl_req_data_i;
        entry_q.id       <= cl_req_id_i;
        entry_q.is_write <= cl_req_is_write_i;
        entry_q.is_read  <= cl_req_is_read_i;
      end
      if (ent_advance) begin
        idx_q  <= idx_q + IDX_W'(1);
        left_q <= left_q - CNT_W'(1);
      end
    end
  end

  assign snoop_valid_o   = (state_q == ST_REQ_CNT) || (state_q == ST_REQ_ENT);
  assign snoop_request_o = (state_q == ST_REQ_CNT) ? count_req(src_q) : entry_req(src_q);
  assign snoop_addr_o    = ADDR_WIDTH'(idx_q);

  assign dump_valid_o    = (state_q == ST_EMIT);
  assign dump_addr_o     = entry_q.addr;
  assign dump_data_o     = entry_q.data;
  assign dump_id_o       = entry_q.id;
  assign dump_is_write_o = entry_q.is_write;
  assign dump_is_read_o  = entry_q.is_read;
  assign dump_last_o     = dump_valid_o && last_entry;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_npu_log_snooper.sv
// Self-checking bench for npu_log_snooper: a behavioural logger answers snoops, a monitor
// records DUT activity, and each test task compares it against a model-built expected queue.
module tb_npu_log_snooper;
  import npu_log_snooper_pkg::*;

  localparam int LS = 4;
  localparam int DW = 512;
  localparam int AW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] id;
    logic          w;
    logic          r;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic dump_start_i, dump_source_i, dump_abort_i, dump_ready_i;
  logic [AW-1:0] flo, fhi;
  logic snoop_valid_o;
  log_snoop_req_t snoop_request_o;
  logic [AW-1:0] snoop_addr_o;
  logic cl_valid_i, cl_req_is_write_i, cl_req_is_read_i;
  logic [AW-1:0] cl_req_addr_i, cl_req_id_i;
  logic [DW-1:0] cl_req_data_i;
  logic dump_valid_o, dump_is_write_o, dump_is_read_o, dump_last_o, busy_o, done_o;
  logic [AW-1:0] dump_addr_o, dump_id_o;
  logic [DW-1:0] dump_data_o;

  npu_log_snooper #(.LOG_SIZE(LS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .dump_start_i(dump_start_i), .dump_source_i(dump_source_i), .dump_abort_i(dump_abort_i),
`ifdef NPU_LOG_SNOOPER_FILTER_EN
    .filter_lo_i(flo), .filter_hi_i(fhi),
`endif
    .snoop_valid_o(snoop_valid_o), .snoop_request_o(snoop_request_o), .snoop_addr_o(snoop_addr_o),
    .cl_valid_i(cl_valid_i), .cl_req_addr_i(cl_req_addr_i), .cl_req_data_i(cl_req_data_i),
    .cl_req_id_i(cl_req_id_i), .cl_req_is_write_i(cl_req_is_write_i), .cl_req_is_read_i(cl_req_is_read_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o), .dump_id_o(dump_id_o),
    .dump_is_write_o(dump_is_write_o), .dump_is_read_o(dump_is_read_o),
    .dump_last_o(dump_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  // logger model contents, written by the test tasks
  beat_t core_log [LS];
  beat_t mem_log  [LS];
  int    core_count, mem_count;
  int    resp_delay_ent;

  // scoreboard
  beat_t exp_q [$];
  logic [AW-1:0] last_pushed_addr;
  int n_cmp, n_bad;
  int obs_rd;

  // monitor-owned records
  beat_t          obs_q [$];
  int             obs_cyc [$];
  logic [AW-1:0]  snp_addr_q [$];
  log_snoop_req_t snp_req_q [$];
  int             snp_cyc_q [$];
  int             done_cnt, done_cyc, valid_cnt, cyc;

  initial begin
    done_cnt = 0; done_cyc = -1; valid_cnt = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (dump_valid_o) valid_cnt++;
      if (dump_valid_o && dump_ready_i) begin
        obs_q.push_back('{dump_addr_o, dump_data_o, dump_id_o, dump_is_write_o, dump_is_read_o, dump_last_o});
        obs_cyc.push_back(cyc);
      end
      if (snoop_valid_o) begin
        snp_addr_q.push_back(snoop_addr_o);
        snp_req_q.push_back(snoop_request_o);
        snp_cyc_q.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // logger responder: answers one cycle after the snoop strobe (entry answers optionally later)
  initial begin
    log_snoop_req_t rq;
    int ri;
    beat_t e;
    cl_valid_i = 1'b0; cl_req_addr_i = '0; cl_req_data_i = '0; cl_req_id_i = '0;
    cl_req_is_write_i = 1'b0; cl_req_is_read_i = 1'b0;
    forever begin
      @(negedge clk);
      if (snoop_valid_o) begin
        rq = snoop_request_o;
        ri = int'(snoop_addr_o % LS);
        if (rq == SNOOP_CORE || rq == SNOOP_MEM) repeat (1 + resp_delay_ent) @(posedge clk);
        else @(posedge clk);
        #1;
        e = '0;
        case (rq)
          GET_CORE_EVENTS: e.id = AW'(core_count);
          GET_MEM_EVENTS:  e.id = AW'(mem_count);
          SNOOP_CORE:      e = core_log[ri];
          default:         e = mem_log[ri];
        endcase
        cl_valid_i = 1'b1;
        cl_req_addr_i = e.addr; cl_req_data_i = e.data; cl_req_id_i = e.id;
        cl_req_is_write_i = e.w; cl_req_is_read_i = e.r;
        @(posedge clk); #1;
        cl_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk_entry(input logic [AW-1:0] a, input logic [AW-1:0] id, input int k);
    beat_t b;
    b.addr = a;
    b.data = {16{a ^ 32'hA5A5_0000}};
    b.id   = id;
    b.w    = k[0];
    b.r    = ~k[0];
    b.last = 1'b0;
    return b;
  endfunction

  function automatic void fill_log(input logic src, input logic [AW-1:0] base, input logic [AW-1:0] step,
                                   input logic [AW-1:0] idbase);
    for (int k = 0; k < LS; k++) begin
      if (src) mem_log[k]  = mk_entry(base + step * AW'(k), idbase + AW'(k), k);
      else     core_log[k] = mk_entry(base + step * AW'(k), idbase + AW'(k), k);
    end
  endfunction

  // reference walk: n = min(C, LS), oldest first, wrap modulo LS
  function automatic void push_expected(input logic src, input int c);
    int n, first, idx;
    beat_t b;
    n = (c > LS) ? LS : c;
    first = (c > LS) ? (c % LS) : 0;
    for (int k = 0; k < n; k++) begin
      idx = (first + k) % LS;
      b = src ? mem_log[idx] : core_log[idx];
`ifdef NPU_LOG_SNOOPER_FILTER_EN
      if (b.addr < flo || b.addr > fhi) continue;
`endif
      b.last = (k == n - 1);
      exp_q.push_back(b);
      last_pushed_addr = b.addr;
    end
  endfunction

  task automatic pulse_start(input logic src);
    dump_source_i = src;
    dump_start_i = 1'b1;
    @(posedge clk); #1;
    dump_start_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (dump_valid_o !== 1'b0 || dump_last_o !== 1'b0)
      begin n_bad++; $display("FAIL reset_dump_valid: got valid=%b last=%b want 0/0", dump_valid_o, dump_last_o); end
    n_cmp++; if (snoop_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_snoop_valid: got %b want 0", snoop_valid_o); end
    n_cmp++; if (snoop_request_o !== SNOOP_CORE || snoop_addr_o !== '0)
      begin n_bad++; $display("FAIL reset_snoop_req: got req=%0d addr=%h want 0/0", snoop_request_o, snoop_addr_o); end
    n_cmp++; if (dump_addr_o !== '0 || dump_id_o !== '0 || dump_data_o !== '0)
      begin n_bad++; $display("FAIL reset_fields: got addr=%h id=%h want 0", dump_addr_o, dump_id_o); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_core_three();
    bit ok;
    int sb, db, nexp;
    beat_t e;
    fill_log(1'b0, 32'h10, 32'h4, 32'h0);
    core_count = 3;
    push_expected(1'b0, 3);
    nexp = exp_q.size();
    obs_rd = obs_q.size(); sb = snp_req_q.size(); db = done_cnt;
    pulse_start(1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL core3_timeout: busy still %b, want 0", busy_o); end
    n_cmp++; if (snp_req_q.size() <= sb || snp_req_q[sb] !== GET_CORE_EVENTS)
      begin n_bad++; $display("FAIL core3_count_req: got %0d want %0d", (snp_req_q.size() > sb) ? int'(snp_req_q[sb]) : -1, GET_CORE_EVENTS); end
    for (int k = 0; k < nexp; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_bad++; $display("FAIL core3_beat%0d: got none want addr=%h", k, e.addr); end
      else begin
        if (obs_q[obs_rd] !== e) begin n_bad++;
          $display("FAIL core3_beat%0d: got addr=%h id=%h w=%b r=%b last=%b want addr=%h id=%h w=%b r=%b last=%b", k,
                   obs_q[obs_rd].addr, obs_q[obs_rd].id, obs_q[obs_rd].w, obs_q[obs_rd].r, obs_q[obs_rd].last,
                   e.addr, e.id, e.w, e.r, e.last); end
        obs_rd++;
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_bad++; $display("FAIL core3_beat_count: got %0d extra beats want 0", obs_q.size() - obs_rd); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL core3_done_count: got %0d want 1", done_cnt - db); end
    n_cmp++; if (obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1)
      begin n_bad++; $display("FAIL core3_done_timing: got cycle %0d want one after last beat", done_cyc); end
  endtask

  task automatic test_empty_mem();
    bit ok;
    int sb, db, vb;
    mem_count = 0;
    obs_rd = obs_q.size(); sb = snp_req_q.size(); db = done_cnt; vb = valid_cnt;
    pulse_start(1'b1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL empty_timeout: busy still %b, want 0", busy_o); end
    n_cmp++; if (snp_req_q.size() != sb + 1 || snp_req_q[sb] !== GET_MEM_EVENTS)
      begin n_bad++; $display("FAIL empty_snoops: got %0d snoops want 1 GET_MEM_EVENTS", snp_req_q.size() - sb); end
    n_cmp++; if (valid_cnt != vb) begin n_bad++; $display("FAIL empty_no_beat: got %0d valid cycles want 0", valid_cnt - vb); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL empty_done_count: got %0d want 1", done_cnt - db); end
    n_cmp++; if (snp_cyc_q.size() <= sb || done_cyc != snp_cyc_q[sb] + 2)
      begin n_bad++; $display("FAIL empty_done_timing: got cycle %0d want two after count request", done_cyc); end
  endtask

  task automatic test_wrap();
    bit ok;
    int sb, db, nexp;
    int want_idx [4] = '{2, 3, 0, 1};
    beat_t e;
    fill_log(1'b0, 32'h1000, 32'h40, 32'h50);
    core_count = 6;
    push_expected(1'b0, 6);
    nexp = exp_q.size();
    obs_rd = obs_q.size(); sb = snp_req_q.size(); db = done_cnt;
    pulse_start(1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: busy still %b, want 0", busy_o); end
    n_cmp++; if (snp_addr_q.size() != sb + 5) begin n_bad++; $display("FAIL wrap_snoop_count: got %0d want 5", snp_addr_q.size() - sb); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (snp_addr_q[sb+1+k] !== AW'(want_idx[k]) || snp_req_q[sb+1+k] !== SNOOP_CORE)
        begin n_bad++; $display("FAIL wrap_snoop_addr%0d: got %0d want %0d", k, snp_addr_q[sb+1+k], want_idx[k]); end
    end
    for (int k = 0; k < nexp; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_bad++; $display("FAIL wrap_beat%0d: got none want addr=%h", k, e.addr); end
      else begin
        if (obs_q[obs_rd] !== e) begin n_bad++;
          $display("FAIL wrap_beat%0d: got addr=%h id=%h last=%b want addr=%h id=%h last=%b", k,
                   obs_q[obs_rd].addr, obs_q[obs_rd].id, obs_q[obs_rd].last, e.addr, e.id, e.last); end
        obs_rd++;
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_bad++; $display("FAIL wrap_beat_count: got %0d extra beats want 0", obs_q.size() - obs_rd); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int nexp;
    beat_t e;
    fill_log(1'b0, 32'h200, 32'h8, 32'h20);
    core_count = 2;
    push_expected(1'b0, 2);
    nexp = exp_q.size();
    obs_rd = obs_q.size();
    dump_ready_i = 1'b0;
    pulse_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dump_valid_o) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL stall_first_valid: got no beat within 30 cycles, want one"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dump_valid_o !== 1'b1 || dump_addr_o !== exp_q[0].addr || dump_id_o !== exp_q[0].id ||
          dump_data_o !== exp_q[0].data || snoop_valid_o !== 1'b0)
        begin n_bad++; $display("FAIL stall_hold%0d: got valid=%b addr=%h id=%h snoop=%b want 1/%h/%h/0", i,
                                dump_valid_o, dump_addr_o, dump_id_o, snoop_valid_o, exp_q[0].addr, exp_q[0].id); end
    end
    @(posedge clk); #1;
    dump_ready_i = 1'b1;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: busy still %b, want 0", busy_o); end
    for (int k = 0; k < nexp; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_bad++; $display("FAIL stall_beat%0d: got none want addr=%h", k, e.addr); end
      else begin
        if (obs_q[obs_rd] !== e) begin n_bad++;
          $display("FAIL stall_beat%0d: got addr=%h id=%h last=%b want addr=%h id=%h last=%b", k,
                   obs_q[obs_rd].addr, obs_q[obs_rd].id, obs_q[obs_rd].last, e.addr, e.id, e.last); end
        obs_rd++;
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_bad++; $display("FAIL stall_beat_count: got %0d extra beats want 0", obs_q.size() - obs_rd); end
  endtask

  task automatic test_abort();
    bit ok, seen;
    int sb, db, vb, nexp;
    logic [AW-1:0] prev_addr;
    beat_t e;
    prev_addr = last_pushed_addr;
    // start and abort together in IDLE: nothing starts
    sb = snp_req_q.size();
    dump_start_i = 1'b1; dump_abort_i = 1'b1; dump_source_i = 1'b0;
    @(posedge clk); #1;
    dump_start_i = 1'b0; dump_abort_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0 || snp_req_q.size() != sb)
      begin n_bad++; $display("FAIL abort_idle_start: got busy=%b snoops=%0d want 0/0", busy_o, snp_req_q.size() - sb); end

    fill_log(1'b0, 32'h7000, 32'h10, 32'h90);
    core_count = 3;
    resp_delay_ent = 1;
    db = done_cnt; vb = valid_cnt; obs_rd = obs_q.size();
    pulse_start(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snoop_valid_o && snoop_request_o == SNOOP_CORE) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL abort_entry_req: got no entry snoop within 20 cycles, want one"); end
    @(posedge clk); #1;
    dump_abort_i = 1'b1;
    @(posedge clk); #1;
    dump_abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_to_idle: got busy=%b want 0", busy_o); end
    repeat (6) @(posedge clk); #1;
    resp_delay_ent = 0;
    n_cmp++; if (valid_cnt != vb || obs_q.size() != obs_rd)
      begin n_bad++; $display("FAIL abort_no_beat: got %0d valid cycles want 0", valid_cnt - vb); end
    n_cmp++; if (done_cnt != db) begin n_bad++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - db); end
    n_cmp++; if (dump_addr_o !== prev_addr) begin n_bad++; $display("FAIL abort_stray_discard: got addr=%h want %h", dump_addr_o, prev_addr); end

    push_expected(1'b0, 3);
    nexp = exp_q.size();
    db = done_cnt;
    pulse_start(1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_restart_timeout: busy still %b, want 0", busy_o); end
    for (int k = 0; k < nexp; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_bad++; $display("FAIL restart_beat%0d: got none want addr=%h", k, e.addr); end
      else begin
        if (obs_q[obs_rd] !== e) begin n_bad++;
          $display("FAIL restart_beat%0d: got addr=%h id=%h last=%b want addr=%h id=%h last=%b", k,
                   obs_q[obs_rd].addr, obs_q[obs_rd].id, obs_q[obs_rd].last, e.addr, e.id, e.last); end
        obs_rd++;
      end
    end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - db); end
  endtask

`ifdef NPU_LOG_SNOOPER_FILTER_EN
  task automatic test_filter();
    bit ok;
    int db, nexp;
    beat_t e;
    core_log[0] = mk_entry(32'h80,  32'h0, 0);
    core_log[1] = mk_entry(32'h140, 32'h1, 1);
    core_log[2] = mk_entry(32'h300, 32'h2, 2);
    core_count = 3;
    flo = 32'h100; fhi = 32'h1FF;
    push_expected(1'b0, 3);
    nexp = exp_q.size();
    obs_rd = obs_q.size(); db = done_cnt;
    pulse_start(1'b0);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL filter_timeout: busy still %b, want 0", busy_o); end
    for (int k = 0; k < nexp; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_bad++; $display("FAIL filter_beat%0d: got none want addr=%h", k, e.addr); end
      else begin
        if (obs_q[obs_rd] !== e) begin n_bad++;
          $display("FAIL filter_beat%0d: got addr=%h last=%b want addr=%h last=%b", k,
                   obs_q[obs_rd].addr, obs_q[obs_rd].last, e.addr, e.last); end
        obs_rd++;
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_bad++; $display("FAIL filter_beat_count: got %0d extra beats want 0", obs_q.size() - obs_rd); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL filter_done_count: got %0d want 1", done_cnt - db); end
    flo = '0; fhi = '1;
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    dump_start_i = 1'b0; dump_source_i = 1'b0; dump_abort_i = 1'b0; dump_ready_i = 1'b1;
    flo = '0; fhi = '1;
    core_count = 0; mem_count = 0; resp_delay_ent = 0;
    last_pushed_addr = '0;
    fill_log(1'b0, 32'h0, 32'h4, 32'h0);
    fill_log(1'b1, 32'h8000, 32'h4, 32'h0);
    test_reset();
    test_core_three();
    test_empty_mem();
    test_wrap();
    test_stall();
    test_abort();
`ifdef NPU_LOG_SNOOPER_FILTER_EN
    test_filter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
